ro_bank_ctrl: RTL and testbench

Register-mapped controller for a bank of NUM_CH ring-oscillator (power-waster) instances. It generalises single-RO enable to per-channel enable masks, free-running or cycle-timed run windows, per-channel synchronised activity counters and status readback. It sits behind the CL OCL write-decode/read-response path and drives the RO enable pins directly.

---
 rtl/ro_bank_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ro_bank_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_bank_ctrl.sv
// ro_bank_ctrl: register-mapped controller for a bank of NUM_CH ring oscillators.
//   Provides per-channel enable masks, free-running or cycle-timed run windows,
//   per-channel synchronised activity counters and status/counter readback.
// Ports:
//   clk_main_a0, rst_main      clock, async active-high reset
//   wr_addr/wready/wdata       single-cycle register write strobe
//   arvalid_q/araddr_q         one-cycle read request
//   rready/rvalid/rdata/rresp  read response handshake (rresp always OKAY)
//   ro_en[NUM_CH]              registered RO enables, EN_MASK while in RUN
//   ro_out[NUM_CH]             raw RO outputs, asynchronous to clk_main_a0
//   run_active                 high while in RUN
//   done_pulse                 one-cycle pulse on a timed RUN->DONE

// Per-channel synchroniser, edge detector and saturating activity counter.
module ro_bank_ch #(
  parameter int COUNT_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_main_a0,
  input  logic               rst_main,
  input  logic               ro_raw,
  input  logic               run,
  input  logic               clr,
  output logic               synced,
  output logic [COUNT_W-1:0] cnt
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_raw};
      prev_q <= synced;
      // Clear wins over a same-cycle edge; counter sticks at all-ones.
      if (clr)
        cnt <= '0;
      else if (run && rise && (cnt != {COUNT_W{1'b1}}))
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module ro_bank_ctrl #(
  parameter int          NUM_CH      = 4,
  parameter int          COUNT_W     = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0600,
  parameter logic [31:0] UNIMPL_VAL  = 32'hDEAD_BEEF
) (
  input  logic              clk_main_a0,
  input  logic              rst_main,
  input  logic [31:0]       wr_addr,
  input  logic              wready,
  input  logic [31:0]       wdata,
  input  logic              arvalid_q,
  input  logic [31:0]       araddr_q,
  input  logic              rready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic [NUM_CH-1:0] ro_en,
  input  logic [NUM_CH-1:0] ro_out,
  output logic              run_active,
  output logic              done_pulse
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [31:0]       wr_off, rd_off;
  logic              ctrl_wr, start, stop, clr_cnt;
  logic [31:0]       scratch_q, duration_q, timer_q;
  logic [NUM_CH-1:0] en_mask_q;
  logic              timed_q;
  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] ro_en_d;
  logic              done_d;
  logic [NUM_CH-1:0] synced;
  logic [NUM_CH-1:0][COUNT_W-1:0] cnt;
  logic [31:0]       rd_val;

  assign wr_off  = wr_addr - BASE_ADDR;
  assign rd_off  = araddr_q - BASE_ADDR;
  assign ctrl_wr = wready && (wr_off == 32'h04);
  assign start   = ctrl_wr && wdata[0];
  assign stop    = ctrl_wr && wdata[1];
  assign clr_cnt = ctrl_wr && wdata[2];

  // Configuration registers and run timer
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      scratch_q  <= '0;
      en_mask_q  <= '0;
      duration_q <= '0;
      timer_q    <= '0;
      timed_q    <= 1'b0;
    end else begin
      if (wready && wr_off == 32'h00) scratch_q  <= wdata;
      if (wready && wr_off == 32'h08) en_mask_q  <= wdata[NUM_CH-1:0];
      if (wready && wr_off == 32'h0C) duration_q <= wdata;
      // STOP beats START; a timer of zero on START means free-run.
      if (stop) begin
        timer_q <= '0;
        timed_q <= 1'b0;
      end else if (start) begin
        timer_q <= duration_q;
        timed_q <= (duration_q != '0);
      end else if (state_q == ST_RUN && timed_q && timer_q != '0) begin
        timer_q <= timer_q - 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      state_q    <= ST_IDLE;
      ro_en      <= '0;
      done_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      ro_en      <= ro_en_d;
      done_pulse <= done_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (stop)                         state_d = ST_IDLE;
        else if (start)                   state_d = ST_RUN;
        else if (timed_q && timer_q == 1) state_d = ST_DONE;
      end
      default: begin
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
      end
    endcase
  end

  // FSM: outputs, registered from next state so ro_en tracks RUN exactly
  always_comb begin
    ro_en_d = (state_d == ST_RUN) ? en_mask_q : '0;
    done_d  = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  assign run_active = (state_q == ST_RUN);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      ro_bank_ch #(.COUNT_W(COUNT_W), .SYNC_STAGES(SYNC_STAGES)) u_ch (
        .clk_main_a0 (clk_main_a0),
        .rst_main    (rst_main),
        .ro_raw      (ro_out[g]),
        .run         (run_active),
        .clr         (clr_cnt),
        .synced      (synced[g]),
        .cnt         (cnt[g])
      );
    end
  endgenerate

  // Read decode; CTRL is write-only and reads back as zero.
  always_comb begin
    rd_val = UNIMPL_VAL;
    case (rd_off)
      32'h00: rd_val = scratch_q;
      32'h04: rd_val = '0;
      32'h08: begin rd_val = '0; rd_val[NUM_CH-1:0] = en_mask_q; end
      32'h0C: rd_val = duration_q;
      32'h10: begin
        rd_val = '0;
        rd_val[31:30] = state_q;
        rd_val[NUM_CH-1:0] = synced;
      end
      32'h14: rd_val = timer_q;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (rd_off == 32'h20 + 32'(4 * i)) begin
            rd_val = '0;
            rd_val[COUNT_W-1:0] = cnt[i];
          end
        end
      end
    endcase
  end

  // Read response: capture on request, hold until accepted; requests
  // arriving while a response is pending are dropped.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (arvalid_q && !rvalid) begin
      rvalid <= 1'b1;
      rdata  <= rd_val;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end
  end

  assign rresp = 2'b00;
endmodule

// File: tb/tb_ro_bank_ctrl.sv
module tb_ro_bank_ctrl;
  localparam logic [31:0] BASE = 32'h0000_0600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wr_addr = '0, wdata = '0, araddr_q = '0;
  logic        wready = 1'b0, arvalid_q = 1'b0, rready = 1'b0;
  logic [3:0]  ro_out = '0, ro8 = '0;
  logic        rvalid, rvalid8, run_active, run8, done_pulse, done8;
  logic [31:0] rdata, rdata8;
  logic [1:0]  rresp, rresp8;
  logic [3:0]  ro_en, ro_en8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ro_bank_ctrl dut (
    .clk_main_a0(clk), .rst_main(rst), .wr_addr(wr_addr), .wready(wready),
    .wdata(wdata), .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .ro_en(ro_en),
    .ro_out(ro_out), .run_active(run_active), .done_pulse(done_pulse));

  ro_bank_ctrl #(.COUNT_W(8)) dut8 (
    .clk_main_a0(clk), .rst_main(rst), .wr_addr(wr_addr), .wready(wready),
    .wdata(wdata), .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready),
    .rvalid(rvalid8), .rdata(rdata8), .rresp(rresp8), .ro_en(ro_en8),
    .ro_out(ro8), .run_active(run8), .done_pulse(done8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input logic [31:0] act,
                         input logic [31:0] lo, input logic [31:0] hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    wready = 1'b1; wr_addr = BASE + off; wdata = d;
    @(negedge clk);
    wready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d, output logic [31:0] d8);
    int n;
    n = 0;
    @(negedge clk);
    arvalid_q = 1'b1; araddr_q = BASE + off;
    @(negedge clk);
    arvalid_q = 1'b0;
    while (!rvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) chk("rd_timeout", 32'(rvalid), 32'd1);
    d = rdata; d8 = rdata8;
    chk("rresp", 32'(rresp), 32'd0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic toggle(input int which, input int n_tog);
    for (int i = 0; i < n_tog; i++) begin
      repeat (4) @(negedge clk);
      if (which == 0) ro_out[1] = ~ro_out[1];
      else            ro8[0]    = ~ro8[0];
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] off;
    logic [31:0] data;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [31:0] d, d8, held;
    int on_cnt, pulses;

    tbl[0]  = '{0, 32'h000, 32'h0,         32'h0,         "rst_scratch"};
    tbl[1]  = '{0, 32'h008, 32'h0,         32'h0,         "rst_en_mask"};
    tbl[2]  = '{0, 32'h020, 32'h0,         32'h0,         "rst_cnt0"};
    tbl[3]  = '{0, 32'h1FC, 32'h0,         32'hDEAD_BEEF, "unmapped_1fc"};
    tbl[4]  = '{0, 32'h010, 32'h0,         32'h0,         "rst_status"};
    tbl[5]  = '{0, 32'h014, 32'h0,         32'h0,         "rst_timer"};
    tbl[6]  = '{1, 32'h000, 32'hA5A5_0F0F, 32'h0,         "wr_scratch"};
    tbl[7]  = '{0, 32'h000, 32'h0,         32'hA5A5_0F0F, "scratch_rw"};
    tbl[8]  = '{1, 32'h008, 32'hFFFF_FFFF, 32'h0,         "wr_en_mask"};
    tbl[9]  = '{0, 32'h008, 32'h0,         32'h0000_000F, "en_mask_width"};
    tbl[10] = '{1, 32'h010, 32'hFFFF_FFFF, 32'h0,         "wr_status"};
    tbl[11] = '{0, 32'h010, 32'h0,         32'h0,         "status_ro"};
    tbl[12] = '{0, 32'h030, 32'h0,         32'hDEAD_BEEF, "cnt4_unmapped"};
    tbl[13] = '{1, 32'h00C, 32'h0000_1234, 32'h0,         "wr_duration"};
    tbl[14] = '{0, 32'h00C, 32'h0,         32'h0000_1234, "duration_rw"};

    repeat (3) @(negedge clk);
    chk("rst_ro_en", 32'(ro_en), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_run_active", 32'(run_active), 32'h0);
    chk("rst_done_pulse", 32'(done_pulse), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].off, tbl[i].data);
      else begin
        rd(tbl[i].off, d, d8);
        chk(tbl[i].nm, d, tbl[i].exp);
      end
    end

    // Timed run: 10 cycles of ro_en, one done pulse, ends in DONE.
    wr(32'h08, 32'h5);
    wr(32'h0C, 32'd10);
    wr(32'h04, 32'h1);
    on_cnt = 0; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (ro_en == 4'b0101) on_cnt++;
      if (done_pulse) pulses++;
      @(negedge clk);
    end
    chk("timed_ro_en_cycles", 32'(on_cnt), 32'd10);
    chk("timed_done_pulses", 32'(pulses), 32'd1);
    rd(32'h10, d, d8);
    chk("timed_state_done", 32'(d[31:30]), 32'd2);
    rd(32'h14, d, d8);
    chk("timed_timer_zero", d, 32'h0);

    // Free-run counting on channel 1, then STOP.
    wr(32'h0C, 32'd0);
    wr(32'h04, 32'h5);
    pulses = 0;
    fork
      toggle(0, 20);
      for (int i = 0; i < 82; i++) begin
        if (done_pulse) pulses++;
        @(negedge clk);
      end
    join
    wr(32'h04, 32'h2);
    chk("free_no_done_pulse", 32'(pulses + int'(done_pulse)), 32'd0);
    rd(32'h24, d, d8);
    chk_rng("free_cnt1", d, 32'd9, 32'd11);
    rd(32'h10, d, d8);
    chk("free_state_idle", 32'(d[31:30]), 32'd0);

    // Saturation of an 8-bit counter.
    wr(32'h04, 32'h5);
    toggle(1, 600);
    wr(32'h04, 32'h2);
    rd(32'h20, d, d8);
    chk("sat_cnt0_8bit", d8, 32'h0000_00FF);
    chk("sat_other_dut_idle_ch", d, 32'h0);

    // START+STOP in RUN wins as STOP; CLR+START clears and enters RUN.
    wr(32'h04, 32'h1);
    chk("run_ro_en", 32'(ro_en), 32'h5);
    wr(32'h04, 32'h3);
    chk("startstop_ro_en", 32'(ro_en), 32'h0);
    chk("startstop_idle", 32'(run_active), 32'h0);
    wr(32'h04, 32'h5);
    chk("clrstart_run", 32'(run_active), 32'h1);
    rd(32'h24, d, d8);
    chk("clrstart_cnt1", d, 32'h0);
    wr(32'h04, 32'h2);

    // Read held while rready low; a second request is dropped.
    wr(32'h00, 32'h1234_5678);
    @(negedge clk);
    arvalid_q = 1'b1; araddr_q = BASE;
    @(negedge clk);
    arvalid_q = 1'b0;
    chk("hold_rvalid", 32'(rvalid), 32'h1);
    held = rdata;
    chk("hold_rdata", held, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin arvalid_q = 1'b1; araddr_q = BASE + 32'h08; end
      @(negedge clk);
      arvalid_q = 1'b0;
      chk("hold_stable", rdata, 32'h1234_5678);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("hold_release_rvalid", 32'(rvalid), 32'h0);
    chk("hold_release_rdata", rdata, 32'h0);
    @(negedge clk);
    chk("dropped_req", 32'(rvalid), 32'h0);

    // Async reset during a run drops ro_en without a clock edge.
    wr(32'h04, 32'h1);
    chk("prerst_ro_en", 32'(ro_en), 32'h5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ro_en", 32'(ro_en), 32'h0);
    chk("async_rst_run", 32'(run_active), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(32'h00, d, d8);
    chk("post_rst_scratch", d, 32'h0);
    rd(32'h08, d, d8);
    chk("post_rst_en_mask", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
